ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Sequencing controller that shares the 512 x 32 main RAM between two requesters: port 0 (CPU datapath, MAR/MDR side) and port 1 (I/O / program-loader side). It accepts one request at a time, sequences it through the RAM's read/write strobes, captures read data, and returns a one-cycle acknowledge. It sits between the requesters and the RAM and is the only block that drives the RAM strobes.

## Interface
- ADDR_W, 9, RAM address width (512 words)
- DATA_W, 32, RAM data width
- clk  in  1  system clock, rising edge
- clr  in  1  synchronous, active-high reset
- p0_req / p1_req  in  1  request; held high until ack
- p0_we / p1_we  in  1  1 = write, 0 = read; stable while req high
- p0_addr / p1_addr  in  ADDR_W  word address; stable while req high
- p0_wdata / p1_wdata  in  DATA_W  write data; stable while req high
- p0_ack / p1_ack  out  1  one-cycle completion pulse
- p0_rdata / p1_rdata  out  DATA_W  read data; valid in the ack cycle, held until that port's next read ack
- ram_read  out  1  RAM read strobe
- ram_write  out  1  RAM write strobe
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data
- busy  out  1  high in ACCESS and DONE
- grant_id  out  1  port owning the current or last transaction

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any req is high at a clock edge, latch winner's we/addr/wdata, set grant_id, go to ACCESS. Otherwise stay.
- ACCESS: ram_write = we, ram_read = !we. Address and data are driven from latched registers. Next state is DONE.
- DONE: strobes low. For a read, capture ram_rdata into the granted port's rdata register. Pulse the granted port's ack. Next state is IDLE.
- Only one strobe is ever high. The strobe is never high outside ACCESS.
- A write ack leaves that port's rdata unchanged. The non-granted port's ack and rdata never change.
- Arbitration applies only when both req are high in IDLE. With a single requester, that requester wins.
- If req is still high in the cycle after ack, it is a new transaction (back-to-back allowed).
- Request inputs are ignored outside IDLE. Requesters must not change we/addr/wdata before ack.

## Timing
- All outputs are registered.
- Reset values: ack 0, rdata 0, strobes 0, ram_addr 0, ram_wdata 0, busy 0, grant_id 0, state IDLE, round-robin pointer = 1.
- Latency: req sampled at edge N. ACCESS occupies cycle N..N+1 (strobe high). Ack is high for exactly one cycle after edge N+2.
- Throughput is one access per 3 cycles. Maximum wait for a losing port under contention is one transaction (round-robin mode).
- clr high at any edge forces reset values at that edge and abandons any in-flight transaction. No ack is issued for it, and strobes drop at that edge.
- clr has priority over all other inputs.

## Configuration
- RAM_ARB_RR_EN defined: round-robin arbitration.
  - On contention, grant the port other than the last granted.
  - The pointer updates on every grant.
  - After reset the pointer is 1, so port 0 wins the first contention.
- RAM_ARB_RR_EN undefined: fixed priority; port 0 always wins contention. There is no pointer register.

## Structure
- Package ram_arb_pkg:
  - state typedef (IDLE, ACCESS, DONE)
  - ADDR_W/DATA_W default constants
  - port-id constants PORT_CPU = 0, PORT_IO = 1
- One sub-module, ram_arb_grant:
  - Takes both req, an advance enable, clk and clr.
  - Returns the winner id.
  - Contains the round-robin pointer when RAM_ARB_RR_EN is defined.

## Test plan
- Reset: assert clr mid-ACCESS of a p0 write to 0x010. Strobes drop at that edge, no p0_ack, all outputs are at reset values, and state returns to IDLE.
- Single read: RAM[0x05] = 0xDEADBEEF, p0 read 0x05. ram_read is high exactly one cycle, p0_ack pulses 2 cycles after req is sampled, and p0_rdata = 0xDEADBEEF.
- Write then read: p1 writes 0x12345678 to 0x1FF (top address), then p1 reads 0x1FF. p1_rdata = 0x12345678, and p1_rdata is unchanged during the write ack.
- Contention, fixed priority (macro off): both req held high for 4 transactions. All grants go to p0 and p1_ack never pulses.
- Contention, round-robin (macro on): both req held high. Grants are p0, p1, p0, p1. Each ack is 3 cycles apart, with no double strobes.
- Back-to-back: p0 keeps req high across ack with addresses 0x000 then 0x001. Two separate ACCESS cycles occur, each with correct rdata.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM sequencing controller.
// Consumed by ram_arb_grant and ram_arbiter.
`timescale 1ns/1ps
package ram_arb_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 32;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_IO  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Returns {write, read}; exactly one bit is set for any access.
  function automatic logic [1:0] access_strobes(input logic we);
    return {we, ~we};
  endfunction

endpackage

// File: rtl/ram_arb_grant.sv
// Picks the winning port among pending requests.
// RAM_ARB_RR_EN selects round-robin; otherwise port 0 has fixed priority.
`timescale 1ns/1ps
module ram_arb_grant
  import ram_arb_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic req0,
  input  logic req1,
  input  logic advance,
  output logic winner
);

`ifdef RAM_ARB_RR_EN
  logic last_r;

  // Remember the last granted port; reset to PORT_IO so port 0 wins first.
  always_ff @(posedge clk) begin
    if (clr) begin
      last_r <= PORT_IO;
    end else if (advance) begin
      last_r <= winner;
    end else begin
      last_r <= last_r;
    end
  end

  // On contention hand the grant to the port that did not win last time.
  always_comb begin
    winner = PORT_CPU;
    if (req0 && req1) begin
      winner = ~last_r;
    end else if (req1) begin
      winner = PORT_IO;
    end else begin
      winner = PORT_CPU;
    end
  end
`else
  logic unused_s;
  assign unused_s = ^{clk, clr, advance};

  // Port 0 wins whenever it is requesting.
  always_comb begin
    winner = PORT_CPU;
    if (req1 && !req0) begin
      winner = PORT_IO;
    end else begin
      winner = PORT_CPU;
    end
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Shares one 512x32 RAM between a CPU port and an I/O port, one access at a time.
// Define RAM_ARB_RR_EN for round-robin arbitration (default: port 0 priority).
`timescale 1ns/1ps
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              grant_id
);

  state_e            state_r, state_next_s;
  logic              advance_s, winner_s;
  logic              grant_r, grant_s;
  logic              we_r, we_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [DATA_W-1:0] wdata_r, wdata_s;
  logic              ram_read_r, ram_read_s, ram_write_r, ram_write_s;
  logic              p0_ack_r, p0_ack_s, p1_ack_r, p1_ack_s;
  logic [DATA_W-1:0] p0_rdata_r, p0_rdata_s, p1_rdata_r, p1_rdata_s;
  logic              busy_r, busy_s;

  assign advance_s = (state_r == IDLE) && (p0_req || p1_req);

  ram_arb_grant u_grant (
    .clk     (clk),
    .clr     (clr),
    .req0    (p0_req),
    .req1    (p1_req),
    .advance (advance_s),
    .winner  (winner_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: a fixed three-cycle walk once a request is taken.
  always_comb begin
    state_next_s = IDLE;
    case (state_r)
      IDLE: begin
        if (p0_req || p1_req) begin
          state_next_s = ACCESS;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCESS:  state_next_s = DONE;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Output logic: next values for every registered output.
  always_comb begin
    p0_ack_s   = 1'b0;
    p1_ack_s   = 1'b0;
    p0_rdata_s = p0_rdata_r;
    p1_rdata_s = p1_rdata_r;
    busy_s     = (state_next_s != IDLE);

    if (advance_s) begin
      grant_s = winner_s;
      if (winner_s == PORT_IO) begin
        we_s    = p1_we;
        addr_s  = p1_addr;
        wdata_s = p1_wdata;
      end else begin
        we_s    = p0_we;
        addr_s  = p0_addr;
        wdata_s = p0_wdata;
      end
    end else begin
      grant_s = grant_r;
      we_s    = we_r;
      addr_s  = addr_r;
      wdata_s = wdata_r;
    end

    if (state_next_s == ACCESS) begin
      {ram_write_s, ram_read_s} = access_strobes(we_s);
    end else begin
      {ram_write_s, ram_read_s} = 2'b00;
    end

    // RAM read data is valid during DONE, one cycle after the read strobe.
    if (state_r == DONE) begin
      if (grant_r == PORT_IO) begin
        p1_ack_s = 1'b1;
        if (!we_r) begin
          p1_rdata_s = ram_rdata;
        end else begin
          p1_rdata_s = p1_rdata_r;
        end
      end else begin
        p0_ack_s = 1'b1;
        if (!we_r) begin
          p0_rdata_s = ram_rdata;
        end else begin
          p0_rdata_s = p0_rdata_r;
        end
      end
    end else begin
      p0_ack_s = 1'b0;
      p1_ack_s = 1'b0;
    end
  end

  // Output and transaction registers; clr abandons any access in flight.
  always_ff @(posedge clk) begin
    if (clr) begin
      grant_r     <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      ram_read_r  <= 1'b0;
      ram_write_r <= 1'b0;
      p0_ack_r    <= 1'b0;
      p1_ack_r    <= 1'b0;
      p0_rdata_r  <= {DATA_W{1'b0}};
      p1_rdata_r  <= {DATA_W{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      grant_r     <= grant_s;
      we_r        <= we_s;
      addr_r      <= addr_s;
      wdata_r     <= wdata_s;
      ram_read_r  <= ram_read_s;
      ram_write_r <= ram_write_s;
      p0_ack_r    <= p0_ack_s;
      p1_ack_r    <= p1_ack_s;
      p0_rdata_r  <= p0_rdata_s;
      p1_rdata_r  <= p1_rdata_s;
      busy_r      <= busy_s;
    end
  end

  assign p0_ack    = p0_ack_r;
  assign p1_ack    = p1_ack_r;
  assign p0_rdata  = p0_rdata_r;
  assign p1_rdata  = p1_rdata_r;
  assign ram_read  = ram_read_r;
  assign ram_write = ram_write_r;
  assign ram_addr  = addr_r;
  assign ram_wdata = wdata_r;
  assign busy      = busy_r;
  assign grant_id  = grant_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a synchronous 512x32 RAM model.
// Contention expectations follow RAM_ARB_RR_EN when it is defined.
`timescale 1ns/1ps
module tb_ram_arbiter;

`ifdef RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [8:0]  p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_ack, p1_ack;
  logic [31:0] p0_rdata, p1_rdata;
  logic        ram_read, ram_write;
  logic [8:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'd0;
  logic        busy, grant_id;

  logic [31:0] mem [0:511];
  logic        pl_en = 1'b0;
  logic [8:0]  pl_addr = 9'd0;
  logic [31:0] pl_data = 32'd0;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_rd_q [2];

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .clr(clr),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .ram_read(ram_read), .ram_write(ram_write), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy), .grant_id(grant_id)
  );

  // Synchronous RAM: one-cycle read latency, plus a bench-side preload port.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (ram_write) mem[ram_addr] <= ram_wdata;
    if (ram_read) ram_rdata <= mem[ram_addr];
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_vec({tag, ".rd"},    {31'd0, ram_read},  32'd0);
    check_vec({tag, ".wr"},    {31'd0, ram_write}, 32'd0);
    check_vec({tag, ".ack0"},  {31'd0, p0_ack},    32'd0);
    check_vec({tag, ".ack1"},  {31'd0, p1_ack},    32'd0);
    check_vec({tag, ".addr"},  {23'd0, ram_addr},  32'd0);
    check_vec({tag, ".wdata"}, ram_wdata,          32'd0);
    check_vec({tag, ".rdat0"}, p0_rdata,           32'd0);
    check_vec({tag, ".rdat1"}, p1_rdata,           32'd0);
    check_vec({tag, ".busy"},  {31'd0, busy},      32'd0);
    check_vec({tag, ".gid"},   {31'd0, grant_id},  32'd0);
  endtask

  // Walks one transaction from the sampling edge to the ack cycle (and one idle cycle if drop).
  task automatic step_txn(input logic w, input logic we, input logic [8:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input logic drop, input string tag);
    tick();
    check_vec({tag, ".acc.rd"},   {31'd0, ram_read},  {31'd0, ~we});
    check_vec({tag, ".acc.wr"},   {31'd0, ram_write}, {31'd0, we});
    check_vec({tag, ".acc.addr"}, {23'd0, ram_addr},  {23'd0, a});
    check_vec({tag, ".acc.gid"},  {31'd0, grant_id},  {31'd0, w});
    check_vec({tag, ".acc.busy"}, {31'd0, busy},      32'd1);
    check_vec({tag, ".acc.ack"},  {30'd0, p1_ack, p0_ack}, 32'd0);
    if (we) check_vec({tag, ".acc.wdata"}, ram_wdata, wd);
    tick();
    check_vec({tag, ".done.strb"}, {30'd0, ram_write, ram_read}, 32'd0);
    check_vec({tag, ".done.busy"}, {31'd0, busy}, 32'd1);
    check_vec({tag, ".done.ack"},  {30'd0, p1_ack, p0_ack}, 32'd0);
    tick();
    check_vec({tag, ".ack"},      {30'd0, p1_ack, p0_ack}, w ? 32'd2 : 32'd1);
    check_vec({tag, ".ack.busy"}, {31'd0, busy}, 32'd0);
    check_vec({tag, ".ack.strb"}, {30'd0, ram_write, ram_read}, 32'd0);
    if (!we) exp_rd_q[w] = exp_rd;
    check_vec({tag, ".rdat0"}, p0_rdata, exp_rd_q[0]);
    check_vec({tag, ".rdat1"}, p1_rdata, exp_rd_q[1]);
    if (drop) begin
      p0_req = 1'b0;
      p1_req = 1'b0;
      tick();
      check_vec({tag, ".post.ack"},  {30'd0, p1_ack, p0_ack}, 32'd0);
      check_vec({tag, ".post.busy"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    clr = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = 9'd0; p0_wdata = 32'd0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = 9'd0; p1_wdata = 32'd0;
    exp_rd_q[0] = 32'd0;
    exp_rd_q[1] = 32'd0;
    tick();
    preload(9'h005, 32'hDEADBEEF);
    preload(9'h000, 32'hC0C0_0000);
    preload(9'h001, 32'hC1C1_1111);
    preload(9'h020, 32'hAAAA_5555);
    preload(9'h030, 32'hBBBB_6666);
    check_reset_values("rst");
    clr = 1'b0;
    tick();

    // Single read by p0.
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 9'h005;
    step_txn(1'b0, 1'b0, 9'h005, 32'd0, 32'hDEADBEEF, 1'b1, "rd05");

    // p1 write then read at the top address.
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 9'h1FF; p1_wdata = 32'h12345678;
    step_txn(1'b1, 1'b1, 9'h1FF, 32'h12345678, 32'd0, 1'b1, "wr1ff");
    check_vec("wr1ff.mem", mem[9'h1FF], 32'h12345678);
    p1_req = 1'b1; p1_we = 1'b0;
    step_txn(1'b1, 1'b0, 9'h1FF, 32'd0, 32'h12345678, 1'b1, "rd1ff");

    // Back-to-back reads with req held across the ack.
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 9'h000;
    step_txn(1'b0, 1'b0, 9'h000, 32'd0, 32'hC0C0_0000, 1'b0, "b2b0");
    p0_addr = 9'h001;
    step_txn(1'b0, 1'b0, 9'h001, 32'd0, 32'hC1C1_1111, 1'b1, "b2b1");

    // clr in the middle of a p0 write to 0x010.
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 9'h010; p0_wdata = 32'hA5A5A5A5;
    tick();
    check_vec("midrst.wr", {31'd0, ram_write}, 32'd1);
    clr = 1'b1;
    p0_req = 1'b0;
    tick();
    exp_rd_q[0] = 32'd0;
    exp_rd_q[1] = 32'd0;
    check_reset_values("midrst");
    clr = 1'b0;
    tick();
    check_vec("midrst.noack1", {30'd0, p1_ack, p0_ack}, 32'd0);
    tick();
    check_vec("midrst.noack2", {30'd0, p1_ack, p0_ack}, 32'd0);
    check_vec("midrst.busy",   {31'd0, busy}, 32'd0);

    // Contention over four transactions, both requests held.
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 9'h020;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 9'h030;
    for (int t = 0; t < 4; t++) begin
      logic w;
      w = RR ? t[0] : 1'b0;
      step_txn(w, 1'b0, w ? 9'h030 : 9'h020, 32'd0,
               w ? 32'hBBBB_6666 : 32'hAAAA_5555, (t == 3), "cont");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
